vldst_seq: RTL

VLDST_SEQ -- requirements
Module: vldst_seq

---
 rtl/vldst_seq.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/vldst_seq.sv
// rtl/vldst_seq.sv - vector load/store sequencer between a 16-bit memory and a vector register
//
// Moves one vector of ELEMS 16-bit elements between memory and the vector
// register file, one element per cycle, starting at a base address that
// wraps modulo 2^16.
//
// Ports:
//   Clk1        sole clock, all state on its rising edge
//   Reset       synchronous, active-high; aborts any transfer
//   Start       one-cycle request, honoured only while idle
//   Op          0 = load (memory -> VecOut), 1 = store (VecIn -> memory)
//   BaseAddr    memory address of element 0
//   VecIn       store source vector, element i at [16i+15:16i]
//   MemDataIn   memory read data, valid the cycle after a MemRD
//   MemAddr     memory address (0 when no strobe is active)
//   MemRD       memory read strobe
//   MemWR       memory write strobe
//   MemDataOut  memory write data (0 when no strobe is active)
//   VecOut      loaded vector, element i at [16i+15:16i]; held between loads
//   VecWR       one-cycle pulse: VecOut is complete, write it to the register file
//   Busy        high for the whole transfer including the final cycle
//   Done        one-cycle completion pulse

module vldst_seq #(
    parameter int ELEMS = 16
) (
    input  logic                  Clk1,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic                  Op,
    input  logic [15:0]           BaseAddr,
    input  logic [ELEMS*16-1:0]   VecIn,
    input  logic [15:0]           MemDataIn,
    output logic [15:0]           MemAddr,
    output logic                  MemRD,
    output logic                  MemWR,
    output logic [15:0]           MemDataOut,
    output logic [ELEMS*16-1:0]   VecOut,
    output logic                  VecWR,
    output logic                  Busy,
    output logic                  Done
);

    localparam int KW = (ELEMS > 2) ? $clog2(ELEMS) : 1;
    localparam logic [KW-1:0] KLAST = KW'(ELEMS - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DRAIN,
        STORE,
        FIN
    } state_t;

    state_t               state;
    logic [KW-1:0]        k;
    logic                 opLatch;
    logic [15:0]          baseLatch;
    logic [ELEMS*16-1:0]  vecLatch;

    // Element index arithmetic is done in int so that k*16 cannot overflow
    // the narrow counter width.
    int                   kIdx;
    int                   kPrevIdx;
    int                   kNextIdx;
    logic [15:0]          nextAddr;

    assign kIdx     = int'(k);
    assign kPrevIdx = kIdx - 1;
    assign kNextIdx = kIdx + 1;

    // Address of the element after the current one; the 16-bit add wraps.
    assign nextAddr = baseLatch + 16'(k) + 16'd1;

    // Outputs are registered and updated together with the state, so the
    // strobe/address seen in a cycle always belongs to the state of that cycle.
    always_ff @(posedge Clk1) begin
        if (Reset) begin
            state      <= IDLE;
            k          <= '0;
            opLatch    <= 1'b0;
            baseLatch  <= '0;
            vecLatch   <= '0;
            MemAddr    <= '0;
            MemRD      <= 1'b0;
            MemWR      <= 1'b0;
            MemDataOut <= '0;
            VecOut     <= '0;
            VecWR      <= 1'b0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    Done  <= 1'b0;
                    VecWR <= 1'b0;
                    if (Start) begin
                        opLatch   <= Op;
                        baseLatch <= BaseAddr;
                        k         <= '0;
                        Busy      <= 1'b1;
                        MemAddr   <= BaseAddr;
                        if (Op) begin
                            vecLatch   <= VecIn;
                            MemWR      <= 1'b1;
                            MemDataOut <= VecIn[15:0];
                            state      <= STORE;
                        end else begin
                            MemRD <= 1'b1;
                            state <= LOAD;
                        end
                    end
                end

                LOAD: begin
                    // Data for the read issued last cycle arrives now.
                    if (k != '0) begin
                        VecOut[kPrevIdx*16 +: 16] <= MemDataIn;
                    end
                    k <= k + KW'(1);
                    if (k == KLAST) begin
                        MemRD   <= 1'b0;
                        MemAddr <= '0;
                        state   <= DRAIN;
                    end else begin
                        MemAddr <= nextAddr;
                    end
                end

                DRAIN: begin
                    // Last element's data, no new read issued.
                    VecOut[(ELEMS-1)*16 +: 16] <= MemDataIn;
                    Done  <= 1'b1;
                    VecWR <= ~opLatch;
                    state <= FIN;
                end

                STORE: begin
                    if (k == KLAST) begin
                        MemWR      <= 1'b0;
                        MemAddr    <= '0;
                        MemDataOut <= '0;
                        Done       <= 1'b1;
                        VecWR      <= 1'b0;
                        state      <= FIN;
                    end else begin
                        k          <= k + KW'(1);
                        MemAddr    <= nextAddr;
                        MemDataOut <= vecLatch[kNextIdx*16 +: 16];
                    end
                end

                FIN: begin
                    Done  <= 1'b0;
                    VecWR <= 1'b0;
                    Busy  <= 1'b0;
                    k     <= '0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
